// File: rtl/pwm_generator_if.sv
// Control-side bundle for the dual-channel PWM stage: run enable and duty targets in, waveforms and status out.
// Latency: none (plain wiring).
// Backpressure: none; the PWM stage samples targets only at period boundaries.
interface pwm_generator_if #(
  parameter int PWM_RESOLUTION = 16
);
  logic                      en;
  logic [PWM_RESOLUTION-1:0] duty_cycle_l;
  logic [PWM_RESOLUTION-1:0] duty_cycle_r;
  logic                      pwm_l;
  logic                      pwm_r;
  logic                      period_start;
  logic [PWM_RESOLUTION-1:0] duty_active_l;
  logic [PWM_RESOLUTION-1:0] duty_active_r;

  // Control loop side: drives enable and targets, observes the waveforms.
  modport master (
    output en, duty_cycle_l, duty_cycle_r,
    input  pwm_l, pwm_r, period_start, duty_active_l, duty_active_r
  );

  // PWM stage side.
  modport slave (
    input  en, duty_cycle_l, duty_cycle_r,
    output pwm_l, pwm_r, period_start, duty_active_l, duty_active_r
  );
endinterface

// File: rtl/pwm_generator.sv
// Dual-channel edge-aligned PWM with boundary-sampled shadow duties and optional per-period slew limit.
// Latency: duty target -> active up to one period; active duty -> pwm 1 clk; en low -> pwm low 1 clk.
// Backpressure: none; free-running once enabled, period_start strobes each new period.
module pwm_generator #(
  parameter int PWM_RESOLUTION = 16,
  parameter int PRESCALE       = 1,
  parameter int MAX_STEP       = 0
) (
  input logic             clk,
  input logic             reset_n,
  pwm_generator_if.slave  bus
);
  localparam int W  = PWM_RESOLUTION;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Last count of a period; a period spans 0..PERIOD_MAX, i.e. 2^W-1 ticks.
  localparam logic [W-1:0]  PERIOD_MAX = {{(W-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [W:0]    STEP       = (W + 1)'(MAX_STEP);

  logic [PW-1:0] presc;
  logic [W-1:0]  cnt;
  logic [W-1:0]  duty_l;
  logic [W-1:0]  duty_r;
  logic          pwm_l_q;
  logic          pwm_r_q;
  logic          period_start_q;

  logic          tick;
  logic          wrap;
  logic [W-1:0]  next_duty_l;
  logic [W-1:0]  next_duty_r;

  // Move the active duty toward the target by at most STEP; STEP of 0 jumps straight there.
  // Differences are taken one bit wider so neither direction can wrap.
  function automatic logic [W-1:0] slew(input logic [W-1:0] target, input logic [W-1:0] active);
    logic [W:0] diff;
    logic [W:0] res;
    diff = '0;
    res  = {1'b0, active};
    if (STEP == '0) begin
      res = {1'b0, target};
    end else if (target > active) begin
      diff = {1'b0, target} - {1'b0, active};
      res  = {1'b0, active} + ((diff > STEP) ? STEP : diff);
    end else if (target < active) begin
      diff = {1'b0, active} - {1'b0, target};
      res  = {1'b0, active} - ((diff > STEP) ? STEP : diff);
    end
    return res[W-1:0];
  endfunction

  // Tick and period-boundary decode plus the candidate shadow-duty updates.
  always_comb begin
    tick        = (presc == PRESC_LAST);
    wrap        = tick && (cnt == PERIOD_MAX);
    next_duty_l = slew(bus.duty_cycle_l, duty_l);
    next_duty_r = slew(bus.duty_cycle_r, duty_r);
  end

  // Counters, shadow duties and registered outputs. Reset and en low both park the
  // counters on the last tick of a period so the first enabled clk is a boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc          <= PRESC_LAST;
      cnt            <= PERIOD_MAX;
      duty_l         <= '0;
      duty_r         <= '0;
      pwm_l_q        <= 1'b0;
      pwm_r_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else if (!bus.en) begin
      presc          <= PRESC_LAST;
      cnt            <= PERIOD_MAX;
      duty_l         <= '0;
      duty_r         <= '0;
      pwm_l_q        <= 1'b0;
      pwm_r_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        cnt   <= wrap ? '0 : cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (wrap) begin
        duty_l <= next_duty_l;
        duty_r <= next_duty_r;
      end
      pwm_l_q        <= (cnt < duty_l);
      pwm_r_q        <= (cnt < duty_r);
      period_start_q <= wrap;
    end
  end

  assign bus.pwm_l         = pwm_l_q;
  assign bus.pwm_r         = pwm_r_q;
  assign bus.period_start  = period_start_q;
  assign bus.duty_active_l = duty_l;
  assign bus.duty_active_r = duty_r;
endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: two instances (PRESCALE=1/no slew and PRESCALE=3/slew 16)
// share stimulus; a per-clk reference derived from elapsed enabled clks checks every
// output, plus table-driven and hand-written period measurements.
module tb_pwm_generator;
  localparam int W      = 8;
  localparam int PERIOD = 255;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] dl;
  logic [7:0] dr;

  int checks;
  int errors;

  pwm_generator_if #(.PWM_RESOLUTION(W)) if_a ();
  pwm_generator_if #(.PWM_RESOLUTION(W)) if_b ();

  pwm_generator #(.PWM_RESOLUTION(W), .PRESCALE(1), .MAX_STEP(0))  dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a));
  pwm_generator #(.PWM_RESOLUTION(W), .PRESCALE(3), .MAX_STEP(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b));

  assign if_a.en = en;
  assign if_a.duty_cycle_l = dl;
  assign if_a.duty_cycle_r = dr;
  assign if_b.en = en;
  assign if_b.duty_cycle_l = dl;
  assign if_b.duty_cycle_r = dr;

  logic       pwm_l_o [2];
  logic       pwm_r_o [2];
  logic       ps_o    [2];
  logic [7:0] da_l_o  [2];
  logic [7:0] da_r_o  [2];
  assign pwm_l_o[0] = if_a.pwm_l;
  assign pwm_r_o[0] = if_a.pwm_r;
  assign ps_o[0]    = if_a.period_start;
  assign da_l_o[0]  = if_a.duty_active_l;
  assign da_r_o[0]  = if_a.duty_active_r;
  assign pwm_l_o[1] = if_b.pwm_l;
  assign pwm_r_o[1] = if_b.pwm_r;
  assign ps_o[1]    = if_b.period_start;
  assign da_l_o[1]  = if_b.duty_active_l;
  assign da_r_o[1]  = if_b.duty_active_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: n = enabled clks since the last park; ticks happen when n % P == 0,
  // the count is (n / P) mod 255 and boundaries are at n % (255 * P) == 0.
  int presc_cfg [2] = '{1, 3};
  int step_cfg  [2] = '{0, 16};
  int n     [2];
  int pos   [2];
  int mda_l [2];
  int mda_r [2];
  logic e_pwm_l [2];
  logic e_pwm_r [2];
  logic e_ps    [2];

  // Window statistics for period-level measurements.
  int hi_l [2];
  int hi_r [2];
  int ps_n [2];

  typedef struct {
    int dl;
    int dr;
    int exp_l;
    int exp_r;
  } vec_t;
  vec_t vecs [5];

  int up_exp   [7] = '{16, 32, 48, 64, 80, 96, 100};
  int down_exp [6] = '{84, 68, 52, 36, 20, 10};

  function automatic int slew(input int t, input int a, input int s);
    if (s == 0) return t;
    if (t > a) return a + (((t - a) < s) ? (t - a) : s);
    if (t < a) return a - (((a - t) < s) ? (a - t) : s);
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_idle();
    for (int i = 0; i < 2; i++) begin
      n[i] = -1; pos[i] = PERIOD - 1; mda_l[i] = 0; mda_r[i] = 0;
      e_pwm_l[i] = 1'b0; e_pwm_r[i] = 1'b0; e_ps[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit bnd;
    if (!reset_n || !en) begin
      model_idle();
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_pwm_l[i] = (pos[i] < mda_l[i]);
        e_pwm_r[i] = (pos[i] < mda_r[i]);
        n[i]++;
        pos[i] = (n[i] / presc_cfg[i]) % PERIOD;
        bnd = ((n[i] % (PERIOD * presc_cfg[i])) == 0);
        if (bnd) begin
          mda_l[i] = slew(int'(dl), mda_l[i], step_cfg[i]);
          mda_r[i] = slew(int'(dr), mda_r[i], step_cfg[i]);
        end
        e_ps[i] = bnd;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      string tag;
      tag = (i == 0) ? "a" : "b";
      chk({tag, ".pwm_l"},         {31'b0, pwm_l_o[i]}, {31'b0, e_pwm_l[i]});
      chk({tag, ".pwm_r"},         {31'b0, pwm_r_o[i]}, {31'b0, e_pwm_r[i]});
      chk({tag, ".period_start"},  {31'b0, ps_o[i]},    {31'b0, e_ps[i]});
      chk({tag, ".duty_active_l"}, {24'b0, da_l_o[i]},  mda_l[i]);
      chk({tag, ".duty_active_r"}, {24'b0, da_r_o[i]},  mda_r[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    for (int i = 0; i < 2; i++) begin
      hi_l[i] += int'(pwm_l_o[i]);
      hi_r[i] += int'(pwm_r_o[i]);
      ps_n[i] += int'(ps_o[i]);
    end
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      hi_l[i] = 0; hi_r[i] = 0; ps_n[i] = 0;
    end
  endtask

  task automatic wait_ps(input int i);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!ps_o[i] && k < 3000);
    if (!ps_o[i]) begin
      checks++;
      errors++;
      $display("FAIL wait_period_start[%0d] got timeout expected pulse", i);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{dl: 64,  dr: 191, exp_l: 64,  exp_r: 191};
    vecs[1] = '{dl: 0,   dr: 255, exp_l: 0,   exp_r: 255};
    vecs[2] = '{dl: 128, dr: 10,  exp_l: 128, exp_r: 10};
    vecs[3] = '{dl: 254, dr: 1,   exp_l: 254, exp_r: 1};
    vecs[4] = '{dl: 255, dr: 0,   exp_l: 255, exp_r: 0};
    clear_stats();
    model_idle();

    reset_n = 1'b1; en = 1'b0; dl = 8'd0; dr = 8'd0;
    #1 reset_n = 1'b0;
    #1;
    compare_all();
    run(3);
    reset_n = 1'b1;
    en = 1'b1;
    step();
    chk("first_enabled_period_start_a", {31'b0, ps_o[0]}, 32'd1);

    // Table: steady-state high times per 255-clk period on the unprescaled instance.
    for (int v = 0; v < 5; v++) begin
      dl = vecs[v].dl[7:0];
      dr = vecs[v].dr[7:0];
      wait_ps(0);
      wait_ps(0);
      clear_stats();
      run(PERIOD);
      chk($sformatf("vec%0d.high_l", v), hi_l[0], vecs[v].exp_l);
      chk($sformatf("vec%0d.high_r", v), hi_r[0], vecs[v].exp_r);
      chk($sformatf("vec%0d.period_starts", v), ps_n[0], 1);
      chk($sformatf("vec%0d.ps_at_period_end", v), {31'b0, ps_o[0]}, 32'd1);
    end

    // Mid-period target change: current period keeps the old duty.
    dl = 8'd64;
    wait_ps(0);
    wait_ps(0);
    clear_stats();
    run(29);
    dl = 8'd128;
    run(PERIOD - 29);
    chk("midchange.old_period_high", hi_l[0], 64);
    clear_stats();
    run(PERIOD);
    chk("midchange.new_period_high", hi_l[0], 128);

    // Soft start on the slew-limited instance from a fresh enable.
    en = 1'b0; dl = 8'd0;
    run(2);
    en = 1'b1;
    run(4);
    dl = 8'd100;
    for (int j = 0; j < 7; j++) begin
      wait_ps(1);
      chk($sformatf("slew_up%0d", j), {24'b0, da_l_o[1]}, up_exp[j]);
    end
    dl = 8'd10;
    for (int j = 0; j < 6; j++) begin
      wait_ps(1);
      chk($sformatf("slew_down%0d", j), {24'b0, da_l_o[1]}, down_exp[j]);
    end

    // Prescaled period length and high time.
    wait_ps(1);
    clear_stats();
    run(3 * PERIOD);
    chk("presc3.high_l", hi_l[1], 30);
    chk("presc3.period_starts", ps_n[1], 1);
    chk("presc3.ps_at_765", {31'b0, ps_o[1]}, 32'd1);

    // Drop en while high, then re-enable.
    run(5);
    chk("en_drop.pre_high", {31'b0, pwm_l_o[1]}, 32'd1);
    en = 1'b0;
    step();
    chk("en_drop.pwm_low", {31'b0, pwm_l_o[1]}, 32'd0);
    en = 1'b1;
    step();
    chk("en_rise.ps_a", {31'b0, ps_o[0]}, 32'd1);
    chk("en_rise.ps_b", {31'b0, ps_o[1]}, 32'd1);

    // Asynchronous reset mid-period while pwm is high.
    wait_ps(0);
    run(3);
    chk("reset.pre_high", {31'b0, pwm_l_o[0]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_idle();
    compare_all();
    step();
    reset_n = 1'b1;
    step();
    chk("reset_release.ps_a", {31'b0, ps_o[0]}, 32'd1);
    chk("reset_release.da_l_a", {24'b0, da_l_o[0]}, 32'd10);
    run(3);
    chk("reset_release.resume_high", {31'b0, pwm_l_o[0]}, 32'd1);

    // Random targets and enable toggles against the reference.
    for (int r = 0; r < 30; r++) begin
      dl = 8'($urandom_range(0, 255));
      dr = 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 7) != 0);
      run(int'($urandom_range(1, 800)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Dual-channel PWM output stage that turns the left/right wheel duty-cycle words produced by the motor control loop into the physical H-bridge enable waveforms. Duty words are sampled only at period boundaries into shadow registers, so the outputs never glitch. An optional per-period slew limit gives soft-start on each channel. The block sits between motor control and the motor-driver pins and drives a period strobe back to the control side.

## Interface

- PWM_RESOLUTION, 16: width of duty words and of the period counter.
- PRESCALE, 1: clk cycles per PWM counter tick; must be at least 1.
- MAX_STEP, 0: maximum change of the active duty per period on each channel; 0 means no limit, so the active duty jumps straight to the target.

- clk  in  1: system clock; all logic is on the rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- en  in  1: run enable; low forces idle.
- duty_cycle_l  in  PWM_RESOLUTION: left target duty, unsigned.
- duty_cycle_r  in  PWM_RESOLUTION: right target duty, unsigned.
- pwm_l  out  1: left PWM waveform, registered.
- pwm_r  out  1: right PWM waveform, registered.
- period_start  out  1: one-clk pulse marking each new PWM period.
- duty_active_l  out  PWM_RESOLUTION: left duty currently in effect.
- duty_active_r  out  PWM_RESOLUTION: right duty currently in effect.

## Operation

- Define PERIOD_MAX = 2^PWM_RESOLUTION − 2. A PWM period is 2^PWM_RESOLUTION − 1 ticks.
  - Duty 0 gives a constant-low output.
  - Duty 2^PWM_RESOLUTION − 1 gives a constant-high output.
- Prescaler `presc` counts 0..PRESCALE−1. A tick occurs on a clk where `presc` == PRESCALE−1, and `presc` wraps to 0 on that clk. With PRESCALE = 1, every clk is a tick.
- Period counter `cnt` advances by 1 on each tick. On a tick with `cnt` == PERIOD_MAX, it wraps to 0. That wrap is the period boundary.
- At each period boundary, per channel, with target t and active a:
  - t > a: a ← a + min(t − a, MAX_STEP).
  - t < a: a ← a − min(a − t, MAX_STEP).
  - t == a: hold.
  - MAX_STEP = 0: a ← t.
  - Differences are computed at PWM_RESOLUTION+1 bits, unsigned. No wrap-around is possible.
- Duty inputs are ignored between boundaries. A mid-period change takes effect only at the next boundary.
- pwm_x ← (cnt < duty_active_x), compared on register values every clk. pwm therefore lags `cnt` and `duty_active` by one clk.
- period_start ← 1 on the clk edge where the wrap happens, so it is high in the same cycle `cnt` first reads 0. It is 0 otherwise.
- en low (synchronous, takes priority over counting):
  - `cnt` ← PERIOD_MAX and `presc` ← PRESCALE−1 (parked).
  - duty_active_l/r ← 0.
  - pwm_l/r ← 0 and period_start ← 0 on the next edge.
- en rising: the first clk with en high is a tick at PERIOD_MAX, so it is immediately a boundary.
  - period_start pulses and the duty update applies from duty_active = 0, which is the soft-start origin.
  - The first pwm high appears one clk later.
- Reset (reset_n low), effective immediately and asynchronously:
  - Parked state as for en low: `cnt` = PERIOD_MAX, `presc` = PRESCALE−1.
  - All outputs 0: pwm_l, pwm_r, period_start, duty_active_l, duty_active_r.
  - Mid-period reset abandons the period with no completion. Release behaves like en rising if en is high.

## Timing

- Latencies:
  - Duty input to duty_active: up to one full period.
  - duty_active to pwm: 1 clk.
  - en deassert to pwm low: 1 clk.
- High time per period: duty_active × PRESCALE clks. Period length: (2^PWM_RESOLUTION − 1) × PRESCALE clks.
- Both channels share `cnt` and are edge-aligned: both rise in the same cycle after the boundary.
- period_start spacing: exactly one period, except that the first pulse after en or reset occurs on the first enabled clk.

## Test plan

- PWM_RESOLUTION=8, PRESCALE=1, MAX_STEP=0, en=1, duty_l=64, duty_r=191 → every 255-clk period: pwm_l high 64 clks, pwm_r high 191 clks. Rising edges are aligned, one clk after period_start.
- Same configuration, duty_l=0 and duty_r=255 → pwm_l never high, pwm_r constant high after the first boundary, period_start every 255 clks.
- MAX_STEP=16, duty_l steps 0→100 with en already high → duty_active_l reads 16, 32, 48, 64, 80, 96, 100 at successive boundaries. Then a step 100→10 gives 84, 68, 52, 36, 20, 10.
- Change duty_l 64→128 at count 30 → the current period stays at 64 high clks and the next period has 128 high clks. No glitch at the change.
- PRESCALE=3, duty_l=10 → period 765 clks, pwm_l high 30 clks. Then drop en mid-high → pwm_l is 0 on the next clk. Re-raising en gives an immediate period_start.
- Assert reset_n low mid-period with pwm high → all outputs 0 immediately. Release with en=1 → period_start on the first clk, and the waveform resumes from duty_active=0.
